// File: rtl/fp8_pkg.sv
// ============================================================================
// Module      : fp8_pkg
// Description : Shared widths, state encodings, special values and raw-word
//               field positions for the fp8 normalise/round stage.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package fp8_pkg;

    localparam int EXP_W     = 4;
    localparam int MAN_W     = 3;
    localparam int BIAS      = 7;
    localparam int RAW_W     = 16;
    localparam int EXP_INT_W = 8;
    localparam int SIG_W     = 8;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_NORM  = 2'd1;
    localparam state_t ST_ROUND = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Magnitude patterns (everything but the sign bit)
    localparam logic [EXP_W+MAN_W-1:0] INF  = {4'b1111, 3'b000};
    localparam logic [EXP_W+MAN_W-1:0] MAXF = {4'b1110, 3'b111};

    localparam int RAW_SIGN   = 15;
    localparam int RAW_EXP_HI = 14;
    localparam int RAW_EXP_LO = 8;
    localparam int RAW_SIG_HI = 7;
    localparam int RAW_SIG_LO = 0;

    function automatic logic signed [EXP_INT_W-1:0] raw_exp(input logic [RAW_W-1:0] raw);
        return {{(EXP_INT_W - (RAW_EXP_HI - RAW_EXP_LO + 1)){raw[RAW_EXP_HI]}},
                raw[RAW_EXP_HI:RAW_EXP_LO]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp8_round_rne.sv
// ============================================================================
// Module      : fp8_round_rne
// Description : Combinational round-to-nearest-even of a 4-bit significand
//               (hidden + 3 mantissa bits) with exponent adjust and flags.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

import fp8_pkg::*;

module fp8_round_rne #(
    parameter int BIAS = fp8_pkg::BIAS
) (
    input  logic [MAN_W:0]                 m,
    input  logic                           guard,
    input  logic                           st,
    input  logic signed [EXP_INT_W-1:0]    exponent,
    output logic [EXP_W-1:0]               field,
    output logic [MAN_W-1:0]               man,
    output logic                           carry,
    output logic                           ovf,
    output logic                           unf
);

    localparam logic signed [EXP_INT_W-1:0] C_EXP_OVF = EXP_INT_W'(2 * BIAS + 1);

    logic                          w_round_up;
    logic [MAN_W+1:0]              w_sum;
    logic [MAN_W:0]                w_m_r;
    logic signed [EXP_INT_W-1:0]   w_exp_r;

    always_comb begin
        w_round_up = guard & (st | m[0]);
        w_sum      = {1'b0, m} + {{(MAN_W + 1){1'b0}}, w_round_up};
        carry      = w_sum[MAN_W+1];
        w_m_r      = carry ? {1'b1, {MAN_W{1'b0}}} : w_sum[MAN_W:0];
        w_exp_r    = exponent + (carry ? EXP_INT_W'(1) : EXP_INT_W'(0));
        // A subnormal that rounds up sets the hidden bit at E==1, so the
        // field naturally becomes 1 here.
        field      = w_m_r[MAN_W] ? w_exp_r[EXP_W-1:0] : {EXP_W{1'b0}};
        man        = w_m_r[MAN_W-1:0];
        ovf        = w_m_r[MAN_W] && (w_exp_r >= C_EXP_OVF);
        unf        = (field == {EXP_W{1'b0}}) && (guard | st);
    end

endmodule

`default_nettype wire

// File: rtl/fp8_norm_round.sv
// ============================================================================
// Module      : fp8_norm_round
// Description : Iterative normaliser (one shift per clock) plus RNE rounding
//               of a raw fp8 product, valid/ready on both sides.
//               Option FP8_SATURATE_EN: overflow gives max finite, not inf.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

import fp8_pkg::*;

module fp8_norm_round #(
    parameter int BIAS      = fp8_pkg::BIAS,
    parameter int MAX_SHIFT = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_ovf,
    output logic        out_unf
);

    localparam int CNT_W = $clog2(MAX_SHIFT + 1);
    localparam logic [CNT_W-1:0] C_MAX_SHIFT = CNT_W'(MAX_SHIFT);

`ifdef FP8_SATURATE_EN
    localparam bit C_SATURATE = 1'b1;
`else
    localparam bit C_SATURATE = 1'b0;
`endif

    localparam logic [EXP_W+MAN_W-1:0] C_OVF_MAG = C_SATURATE ? MAXF : INF;
    localparam logic [EXP_W+MAN_W-1:0] C_ZERO    = {(EXP_W + MAN_W){1'b0}};

    state_t                       r_state;
    logic                         r_alive;
    logic                         r_sign;
    logic signed [EXP_INT_W-1:0]  r_exp;
    logic [SIG_W-1:0]             r_sig;
    logic                         r_sticky;
    logic [CNT_W-1:0]             r_cnt;
    logic [7:0]                   r_data;
    logic                         r_ovf;
    logic                         r_unf;

    logic                         w_shift;
    logic [SIG_W-1:0]             w_sig_nx;
    logic signed [EXP_INT_W-1:0]  w_exp_nx;
    logic                         w_sticky_nx;
    logic [CNT_W-1:0]             w_cnt_nx;
    logic                         w_flush;

    logic [EXP_W-1:0]             w_field;
    logic [MAN_W-1:0]             w_man;
    logic                         w_carry_unused;
    logic                         w_rnd_ovf;
    logic                         w_rnd_unf;

    assign in_ready  = r_alive && (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign out_data  = r_data;
    assign out_ovf   = r_ovf;
    assign out_unf   = r_unf;

    // Single normalisation step; right shifts (overflowed significand or
    // denormalisation) take priority over the left shift.
    always_comb begin
        w_shift     = 1'b0;
        w_sig_nx    = r_sig;
        w_exp_nx    = r_exp;
        w_sticky_nx = r_sticky;
        if (r_sig[SIG_W-1] || (r_exp < EXP_INT_W'(1))) begin
            w_shift     = 1'b1;
            w_sig_nx    = r_sig >> 1;
            w_exp_nx    = r_exp + EXP_INT_W'(1);
            w_sticky_nx = r_sticky | r_sig[0];
        end else if (!r_sig[SIG_W-2] && (r_exp > EXP_INT_W'(1))) begin
            w_shift     = 1'b1;
            w_sig_nx    = r_sig << 1;
            w_exp_nx    = r_exp - EXP_INT_W'(1);
        end
        w_cnt_nx = r_cnt + CNT_W'(1);
        w_flush  = w_shift && ((w_cnt_nx == C_MAX_SHIFT) || (w_sig_nx == {SIG_W{1'b0}}));
    end

    fp8_round_rne #(
        .BIAS (BIAS)
    ) u_round (
        .m        ({r_sig[6], r_sig[5:3]}),
        .guard    (r_sig[2]),
        .st       (r_sig[1] | r_sig[0] | r_sticky),
        .exponent (r_exp),
        .field    (w_field),
        .man      (w_man),
        .carry    (w_carry_unused),
        .ovf      (w_rnd_ovf),
        .unf      (w_rnd_unf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_alive  <= 1'b0;
            r_sign   <= 1'b0;
            r_exp    <= '0;
            r_sig    <= '0;
            r_sticky <= 1'b0;
            r_cnt    <= '0;
            r_data   <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_sign   <= in_data[RAW_SIGN];
                        r_exp    <= raw_exp(in_data);
                        r_sig    <= in_data[RAW_SIG_HI:RAW_SIG_LO];
                        r_sticky <= 1'b0;
                        r_cnt    <= '0;
                        r_ovf    <= 1'b0;
                        r_unf    <= 1'b0;
                        if (in_data[RAW_SIG_HI:RAW_SIG_LO] == {SIG_W{1'b0}}) begin
                            r_data  <= {in_data[RAW_SIGN], C_ZERO};
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_NORM;
                        end
                    end
                end
                ST_NORM: begin
                    if (w_shift) begin
                        r_sig    <= w_sig_nx;
                        r_exp    <= w_exp_nx;
                        r_sticky <= w_sticky_nx;
                        r_cnt    <= w_cnt_nx;
                        if (w_flush) begin
                            r_data  <= {r_sign, C_ZERO};
                            r_ovf   <= 1'b0;
                            r_unf   <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end else begin
                        r_state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    r_data  <= {r_sign, (w_rnd_ovf ? C_OVF_MAG : {w_field, w_man})};
                    r_ovf   <= w_rnd_ovf;
                    r_unf   <= w_rnd_unf;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fp8_norm_round.sv
// ============================================================================
// Module      : tb_fp8_norm_round
// Description : Directed self-checking bench for fp8_norm_round.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fp8_norm_round;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_ovf;
    logic        out_unf;

    int errors = 0;
    int checks = 0;

`ifdef FP8_SATURATE_EN
    localparam logic [6:0] OVF_MAG = 7'h77;
`else
    localparam logic [6:0] OVF_MAG = 7'h78;
`endif

    fp8_norm_round dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h want=00", out_data); end
        checks++; if ({out_ovf, out_unf} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b want=00", {out_ovf, out_unf}); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_held got=%b want=0", in_ready); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_release got=%b want=1", in_ready); end
    endtask

    // One full transaction: accept, latency in edges from the accept edge
    // (accept edge = 1), result fields, then a single-cycle out_ready.
    task automatic test_vector(input string name, input logic [15:0] d, input logic [7:0] exp_d,
                               input logic exp_ovf, input logic exp_unf, input int exp_lat);
        int n;
        int lat;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready got=%b want=1", name, in_ready); end
        in_data = d; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 30) begin @(posedge clk); #1; lat++; end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s out_valid_timeout got=%b want=1", name, out_valid); end
        checks++; if (lat != exp_lat) begin errors++; $display("FAIL %s latency got=%0d want=%0d", name, lat, exp_lat); end
        checks++; if (out_data !== exp_d) begin errors++; $display("FAIL %s out_data got=%h want=%h", name, out_data, exp_d); end
        checks++; if (out_ovf !== exp_ovf) begin errors++; $display("FAIL %s out_ovf got=%b want=%b", name, out_ovf, exp_ovf); end
        checks++; if (out_unf !== exp_unf) begin errors++; $display("FAIL %s out_unf got=%b want=%b", name, out_unf, exp_unf); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s out_valid_drop got=%b want=0", name, out_valid); end
    endtask

    task automatic test_arith();
        test_vector("one",        16'h0740, 8'h38, 1'b0, 1'b0, 3);
        test_vector("one_5_sq",   16'h0790, 8'h41, 1'b0, 1'b0, 4);
        test_vector("round_up",   16'h07A9, 8'h43, 1'b0, 1'b0, 4);
        test_vector("tie_even",   16'h0764, 8'h3C, 1'b0, 1'b0, 3);
        test_vector("neg_one",    16'h8740, 8'hB8, 1'b0, 1'b0, 3);
        test_vector("left_shift", 16'h0720, 8'h30, 1'b0, 1'b0, 4);
        test_vector("mant_carry", 16'h07FE, 8'h48, 1'b0, 1'b0, 4);
        test_vector("zero",       16'h8700, 8'h80, 1'b0, 1'b0, 1);
    endtask

    task automatic test_overflow();
        test_vector("ovf",       16'h0F40, {1'b0, OVF_MAG}, 1'b1, 1'b0, 3);
        test_vector("ovf_neg",   16'h8F40, {1'b1, OVF_MAG}, 1'b1, 1'b0, 3);
        test_vector("ovf_carry", 16'h0E7F, {1'b0, OVF_MAG}, 1'b1, 1'b0, 3);
    endtask

    task automatic test_underflow();
        test_vector("subnormal",     16'h0040, 8'h04, 1'b0, 1'b0, 4);
        test_vector("sub_inexact",   16'h0041, 8'h04, 1'b0, 1'b1, 4);
        test_vector("sub_to_normal", 16'h007F, 8'h08, 1'b0, 1'b0, 4);
        test_vector("deep_unf",      {1'b0, 7'h70, 8'h40}, 8'h00, 1'b0, 1'b1, 8);
    endtask

    task automatic test_backpressure();
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        in_data = 16'h0740; in_valid = 1'b1;
        @(posedge clk); #1;
        in_data = 16'h0790;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_timeout got=%b want=1", out_valid); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cyc=%0d got=%b want=1", i, out_valid); end
            checks++; if (out_data !== 8'h38) begin errors++; $display("FAIL bp_hold_data cyc=%0d got=%h want=38", i, out_data); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", i, in_ready); end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++; $display("FAIL bp_after valid/ready got=%b%b want=01", out_valid, in_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        pulses = 0;
        out_ready = 1'b1;
        in_data = 16'h0740; in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
                pulses++;
                checks++; if (out_data !== 8'h38) begin errors++; $display("FAIL b2b_data got=%h want=38", out_data); end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++; if (pulses != 3) begin errors++; $display("FAIL b2b_results got=%0d want=3", pulses); end
    endtask

    task automatic test_async_reset();
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        in_data = 16'h0740; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_done_valid got=%b want=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL arst_done_data got=%h want=00", out_data); end
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_done_ready got=%b want=1", in_ready); end

        // Reset in the middle of normalisation of a long right-shift run
        in_data = {1'b0, 7'h70, 8'h40}; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL arst_norm valid/ready got=%b%b want=00", out_valid, in_ready);
        end
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL arst_norm_release valid/ready got=%b%b want=01", out_valid, in_ready);
        end
        test_vector("post_reset", 16'h0790, 8'h41, 1'b0, 1'b0, 4);
    endtask

    initial begin
        test_reset();
        test_arith();
        test_overflow();
        test_underflow();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fp8_norm_round.md
Name: fp8_norm_round

Overview:
- Downstream stage of the 8-bit floating-point multiplier (fp8 operands, 16-bit raw product).
- Takes the raw product word (sign, unbiased-sum exponent, unnormalised significand product) and returns a packed fp8 result.
- Normalises iteratively, one shift per clock, then rounds round-to-nearest-even (RNE).
- Uses a valid/ready handshake on both sides, so the multiplier result can be registered and back-pressured.

Parameters:
- BIAS, 7, fp8 exponent bias (format 1 sign / 4 exponent / 3 mantissa).
- MAX_SHIFT, 9, NORM cycles allowed before a forced flush-to-zero.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  raw product valid
- in_ready  out  1  stage can accept (IDLE only)
- in_data  in  16  [15] sign; [14:8] exponent, 7-bit two's complement (ea+eb-BIAS); [7:0] significand product, format xx.xxxxxx
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_data  out  8  {sign, exp[3:0], man[2:0]}
- out_ovf  out  1  overflow occurred, qualified by out_valid
- out_unf  out  1  result subnormal-inexact or flushed to zero from a nonzero input, qualified by out_valid

Behaviour:
- Reset (asynchronous, any state): state=IDLE; out_valid=0, out_data=0, out_ovf=0, out_unf=0; in_ready=0 while rst is high, 1 afterwards.
- FSM states: IDLE, NORM, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: capture sign, exponent (sign-extended to 8 bits, E), sig[7:0]; clear sticky and shift count S.
  - If sig==0, go to DONE with out_data={sign,7'b0} and no flags.
  - Otherwise go to NORM.
- NORM: each cycle performs at most one action, checked in priority order:
  - sig[7]=1: sig>>=1, E+=1, sticky|=bit shifted out.
  - E<1: sig>>=1, E+=1, sticky|=bit shifted out (denormalise).
  - sig[6]=0 and E>1: sig<<=1, E-=1.
  - Otherwise: no shift; go to ROUND.
  - Each shift increments S. If S reaches MAX_SHIFT, or sig becomes 0, force a signed zero, set out_unf, and go to DONE.
- ROUND:
  - m={sig[6],sig[5:3]}, guard=sig[2], st=sig[1]|sig[0]|sticky.
  - Round up when guard && (st || m[0]).
  - m==4'b1111 plus 1 carries: m=4'b1000, E+=1.
  - Subnormal to normal: if the hidden bit becomes 1 while E==1 after rounding, the exponent field becomes 1.
  - Exponent field = (m[3] ? E : 0).
  - If E>=15: overflow; out_data={sign,4'b1111,3'b000}; out_ovf=1.
  - out_unf=1 when the field is 0 and (guard|st).
  - Go to DONE.
- DONE:
  - out_valid=1; out_data and flags are held stable until out_ready.
  - On out_ready, go to IDLE and drop out_valid.
- Latency:
  - out_valid is high after edge 3+S counted from the accept edge (S = shifts performed).
  - Zero input: after edge 1.
  - Throughput is one result per (4+S) cycles when out_ready is held high.
- in_ready=0 in NORM/ROUND/DONE; upstream must hold in_data until accepted.
- in_valid arriving with out_ready low in DONE: not accepted; no data loss.
- Arithmetic widths:
  - Internal exponent: 8-bit signed; no wrap for any legal input (-64..63 ± 9).
  - sig: 8 bits; sticky: 1 bit.

Optional Feature:
- Macro: FP8_SATURATE_EN.
- Defined: overflow produces the max finite value {sign,4'b1110,3'b111}; out_ovf is still set.
- Undefined: overflow produces infinity {sign,4'b1111,3'b000}.

Decomposition:
- Package fp8_pkg holds:
  - EXP_W=4, MAN_W=3, BIAS, RAW_W=16
  - state enum
  - INF and MAXF constants
  - field-slice helper localparams
- One sub-module: fp8_round_rne, combinational: {m, guard, st, E} -> {field, man, carry, ovf, unf}. The FSM instantiates it in ROUND.

Test Plan:
- 1.0×1.0: in_data=16'h0740 -> out_data=8'h38, no flags, out_valid after edge 3.
- 1.5×1.5: 16'h0790 -> one right shift, 8'h41, out_valid after edge 4.
- Round up: 16'h07A9 -> 8'h43 (2.75). Tie-to-even: 16'h0764 -> 8'h3C (guard=1, st=0, lsb stays 0).
- Overflow: 16'h0F40 -> 8'h78 with out_ovf=1; with FP8_SATURATE_EN, 8'h77.
- Subnormal: 16'h0040 -> 8'h04, out_unf=0. Deep underflow: in_data={1'b0,7'h70,8'h40} -> 8'h00, out_unf=1 within MAX_SHIFT cycles. Zero: 16'h8700 -> 8'h80 after edge 1.
- Handshake/reset:
  - Hold out_ready=0 for 5 cycles in DONE -> out_data stable, in_ready=0, new in_valid ignored.
  - Assert rst mid-NORM -> out_valid=0 immediately (asynchronous); in_ready=1 on the first edge after release.
